// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception controller: takes prioritized exceptions, keeps Status/Cause/EPC,
// and pulses flush/redirect on exception entry and on eret return.
module cp0_exception_unit #(
  parameter int                WIDTH        = 32,
  parameter logic [WIDTH-1:0]  HANDLER_ADDR = 32'h8000_0180
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_req,
  input  logic [2:0]       int_cause,
  input  logic [WIDTH-1:0] pc_D,
  input  logic [WIDTH-1:0] pc_E,
  input  logic             eret_D,
  input  logic [4:0]       cp0_addr,
  input  logic             cp0_we,
  input  logic [WIDTH-1:0] cp0_wdata,
  output logic [WIDTH-1:0] cp0_rdata,
  output logic             flush,
  output logic             redirect,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             in_handler
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TAKE    = 2'd1;
  localparam logic [1:0] ST_HANDLER = 2'd2;
  localparam logic [1:0] ST_RET     = 2'd3;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  function automatic logic [4:0] map_exc_code(input logic [2:0] cause);
    logic [4:0] code;
    case (cause)
      3'd0:    code = 5'd0;
      3'd1:    code = 5'd8;
      3'd2:    code = 5'd9;
      3'd3:    code = 5'd10;
      3'd4:    code = 5'd12;
      default: code = 5'd0;
    endcase
    return code;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [1:0]       status_q, status_d;      // bit0 IE, bit1 EXL
  logic [4:0]       exc_code_q, exc_code_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             flush_q, flush_d;
  logic             redirect_q, redirect_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic accept_s;
  logic eret_take_s;
  logic wr_status_s;
  logic wr_epc_s;

  // Accept/eret decisions and register write strobes
  always_comb begin
    accept_s    = (state_q == ST_IDLE) && exc_req && !status_q[1] &&
                  (int_cause <= 3'd4) && ((int_cause != 3'd0) || status_q[0]);
    eret_take_s = (state_q == ST_HANDLER) && eret_D;
    wr_status_s = cp0_we && (cp0_addr == REG_STATUS);
    wr_epc_s    = cp0_we && (cp0_addr == REG_EPC);
  end

  // Next-state for CP0 registers; accept wins over mtc0 for EXL/EPC, IE from mtc0 still lands
  always_comb begin
    status_d = status_q;
    if (wr_status_s) begin
      status_d = cp0_wdata[1:0];
    end else begin
      status_d = status_q;
    end
    if (accept_s) begin
      status_d[1] = 1'b1;
    end else if (state_q == ST_RET) begin
      status_d[1] = 1'b0;
    end else begin
      status_d[1] = status_d[1];
    end

    if (accept_s) begin
      epc_d      = (int_cause == 3'd4) ? pc_E : pc_D;
      exc_code_d = map_exc_code(int_cause);
    end else if (wr_epc_s) begin
      epc_d      = cp0_wdata;
      exc_code_d = exc_code_q;
    end else begin
      epc_d      = epc_q;
      exc_code_d = exc_code_q;
    end
  end

  // FSM sequencing and registered redirect outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_TAKE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TAKE:    state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (eret_D) begin
          state_d = ST_RET;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      ST_RET:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    flush_d    = accept_s || eret_take_s;
    redirect_d = accept_s || eret_take_s;
    // eret uses epc_d so a same-cycle mtc0 to EPC is honoured
    if (accept_s) begin
      redirect_pc_d = HANDLER_ADDR;
    end else if (eret_take_s) begin
      redirect_pc_d = epc_d;
    end else begin
      redirect_pc_d = {WIDTH{1'b0}};
    end
  end

  // mfc0 read mux reflects pre-edge register contents
  always_comb begin
    case (cp0_addr)
      REG_STATUS: cp0_rdata = {{(WIDTH-2){1'b0}}, status_q};
      REG_CAUSE:  cp0_rdata = {{(WIDTH-7){1'b0}}, exc_code_q, 2'b00};
      REG_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = {WIDTH{1'b0}};
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      status_q      <= 2'b00;
      exc_code_q    <= 5'd0;
      epc_q         <= {WIDTH{1'b0}};
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= {WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      exc_code_q    <= exc_code_d;
      epc_q         <= epc_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign flush       = flush_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign in_handler  = status_q[1];

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: expected redirect targets are queued by the
// stimulus and popped by an independent monitor whenever the DUT pulses redirect.
module tb_cp0_exception_unit;

  localparam logic [31:0] HANDLER = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req;
  logic [2:0]  int_cause;
  logic [31:0] pc_D, pc_E;
  logic        eret_D;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        flush, redirect;
  logic [31:0] redirect_pc;
  logic        in_handler;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic        prev_redirect = 1'b0;

  cp0_exception_unit #(.WIDTH(32), .HANDLER_ADDR(32'h8000_0180)) dut (
    .clk(clk), .rst(rst), .exc_req(exc_req), .int_cause(int_cause),
    .pc_D(pc_D), .pc_E(pc_E), .eret_D(eret_D), .cp0_addr(cp0_addr),
    .cp0_we(cp0_we), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
    .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    cp0_addr = a;
    #1;
    check(name, cp0_rdata, exp);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cp0_we = 1'b1; cp0_addr = a; cp0_wdata = d;
    tick();
    cp0_we = 1'b0;
  endtask

  // Monitor: every redirect pulse must match the next queued target
  always @(negedge clk) begin
    if (redirect || flush) begin
      check("flush_eq_redirect", {31'b0, flush}, {31'b0, redirect});
      if (prev_redirect) check("redirect_back_to_back", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_redirect", redirect_pc, 32'hFFFF_FFFF);
      end else begin
        check("redirect_pc", redirect_pc, exp_q.pop_front());
      end
    end
    prev_redirect = redirect;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; exc_req = 1'b0; int_cause = 3'd0; pc_D = 32'd0; pc_E = 32'd0;
    eret_D = 1'b0; cp0_addr = 5'd0; cp0_we = 1'b0; cp0_wdata = 32'd0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_redirect", {31'b0, redirect}, 32'd0);
    check("rst_in_handler", {31'b0, in_handler}, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    rd(5'd12, 32'd0, "rst_status");
    rd(5'd13, 32'd0, "rst_cause");
    rd(5'd14, 32'd0, "rst_epc");
    tick();

    // Cause is read-only, unmapped registers read 0
    wr(5'd13, 32'hFFFF_FFFF);
    wr(5'd5, 32'h0000_FFFF);
    rd(5'd13, 32'd0, "cause_ro");
    rd(5'd5, 32'd0, "reg5_zero");

    // Masked interrupt is dropped
    exc_req = 1'b1; int_cause = 3'd0; pc_D = 32'h0040_0010;
    tick(); exc_req = 1'b0;
    tick();
    rd(5'd14, 32'd0, "masked_epc");
    check("masked_in_handler", {31'b0, in_handler}, 32'd0);

    // Enable interrupts, then take one
    wr(5'd12, 32'd1);
    rd(5'd12, 32'd1, "status_ie");
    exc_req = 1'b1; int_cause = 3'd0; pc_D = 32'h0040_0010;
    exp_q.push_back(HANDLER);
    tick(); exc_req = 1'b0;
    check("int_in_handler", {31'b0, in_handler}, 32'd1);
    rd(5'd14, 32'h0040_0010, "int_epc");
    rd(5'd13, 32'd0, "int_cause_reg");
    tick();

    // Nested syscall in HANDLER ignored, then eret
    exc_req = 1'b1; int_cause = 3'd1;
    tick(); exc_req = 1'b0;
    rd(5'd13, 32'd0, "nested_cause");
    rd(5'd14, 32'h0040_0010, "nested_epc");
    eret_D = 1'b1; exp_q.push_back(32'h0040_0010);
    tick(); eret_D = 1'b0;
    check("ret_in_handler", {31'b0, in_handler}, 32'd1);
    tick();
    check("after_ret_in_handler", {31'b0, in_handler}, 32'd0);
    rd(5'd12, 32'd1, "after_ret_status");

    // Syscall accepted in the cycle right after RET
    exc_req = 1'b1; int_cause = 3'd1; pc_D = 32'h0040_0030;
    exp_q.push_back(HANDLER);
    tick(); exc_req = 1'b0;
    rd(5'd13, 32'h0000_0020, "sys_cause");
    rd(5'd14, 32'h0040_0030, "sys_epc");
    tick();

    // mtc0 EPC collides with eret
    eret_D = 1'b1; cp0_we = 1'b1; cp0_addr = 5'd14; cp0_wdata = 32'h0040_1000;
    exp_q.push_back(32'h0040_1000);
    tick(); eret_D = 1'b0; cp0_we = 1'b0;
    rd(5'd14, 32'h0040_1000, "coll_epc");
    tick();

    // Overflow captures pc_E
    exc_req = 1'b1; int_cause = 3'd4; pc_E = 32'h0040_0020; pc_D = 32'h0040_0024;
    exp_q.push_back(HANDLER);
    tick(); exc_req = 1'b0;
    rd(5'd14, 32'h0040_0020, "ovf_epc");
    rd(5'd13, 32'h0000_0030, "ovf_cause");
    tick();
    eret_D = 1'b1; exp_q.push_back(32'h0040_0020);
    tick(); eret_D = 1'b0;
    tick();

    // Reserved cause never accepted
    exc_req = 1'b1; int_cause = 3'd5;
    tick(); exc_req = 1'b0;
    tick();
    check("rsv_in_handler", {31'b0, in_handler}, 32'd0);
    rd(5'd13, 32'h0000_0030, "rsv_cause");

    // Accept overrides mtc0 EXL, IE from mtc0 still applies
    exc_req = 1'b1; int_cause = 3'd2; pc_D = 32'h0040_0040;
    cp0_we = 1'b1; cp0_addr = 5'd12; cp0_wdata = 32'd0;
    exp_q.push_back(HANDLER);
    tick(); exc_req = 1'b0; cp0_we = 1'b0;
    rd(5'd12, 32'd2, "acc_coll_status");
    rd(5'd13, 32'h0000_0024, "brk_cause");
    rd(5'd14, 32'h0040_0040, "brk_epc");
    tick();
    eret_D = 1'b1; exp_q.push_back(32'h0040_0040);
    tick(); eret_D = 1'b0;
    tick();
    rd(5'd12, 32'd0, "after_brk_status");

    // eret outside HANDLER is ignored
    eret_D = 1'b1;
    tick(); eret_D = 1'b0;
    tick();

    // Reset in TAKE: pulse already out, nothing after
    wr(5'd12, 32'd1);
    exc_req = 1'b1; int_cause = 3'd3; pc_D = 32'h0040_0050;
    exp_q.push_back(HANDLER);
    tick(); exc_req = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    check("rst2_redirect", {31'b0, redirect}, 32'd0);
    check("rst2_in_handler", {31'b0, in_handler}, 32'd0);
    tick(); tick();
    rd(5'd12, 32'd0, "rst2_status");
    rd(5'd13, 32'd0, "rst2_cause");
    rd(5'd14, 32'd0, "rst2_epc");
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 exception controller for the pipelined MIPS core. It consumes the 3-bit prioritized cause code from the exception cause decoder and, when an exception is taken, captures EPC and Cause. It sets Status.EXL, flushes the pipeline and redirects fetch to the handler vector. It also implements `eret` return and `mfc0`/`mtc0` access to Status (reg 12), Cause (reg 13) and EPC (reg 14).

## Interface
- `WIDTH`, 32, datapath and PC width
- `HANDLER_ADDR`, 32'h8000_0180, exception vector loaded on redirect
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `exc_req`  in  1  any decoder source (interrupt, syscall, break, undef, overflow) active this cycle
- `int_cause`  in  3  decoder code: 0 int, 1 syscall, 2 break, 3 undef, 4 overflow; 5–7 reserved
- `pc_D`  in  WIDTH  PC of decode-stage instruction
- `pc_E`  in  WIDTH  PC of execute-stage instruction
- `eret_D`  in  1  `eret` in decode
- `cp0_addr`  in  5  `mfc0`/`mtc0` register number
- `cp0_we`  in  1  `mtc0` write strobe
- `cp0_wdata`  in  WIDTH  `mtc0` data
- `cp0_rdata`  out  WIDTH  `mfc0` read data (combinational)
- `flush`  out  1  kill IF/ID/EX contents, one cycle
- `redirect`  out  1  force next PC, one cycle
- `redirect_pc`  out  WIDTH  target when `redirect`=1
- `in_handler`  out  1  mirrors Status.EXL

## Operation
- Registers:
  - Status: bit0 IE, bit1 EXL, other bits read 0.
  - Cause: bits[6:2] ExcCode, other bits read 0.
  - EPC: full WIDTH.
- ExcCode map from `int_cause`: 0→0, 1→8, 2→9, 3→10, 4→12. Codes 5–7 never accepted.
- Accept condition, evaluated in state IDLE only: `exc_req`=1, EXL=0, `int_cause`≤4, and (`int_cause`≠0 or IE=1). Masked interrupts are dropped, not queued.
- On accept at edge of cycle T:
  - EPC ← `pc_E` if cause=4, else `pc_D`.
  - Cause.ExcCode ← mapped code.
  - EXL ← 1.
  - State → TAKE.
- FSM states:
  - IDLE: waits for accept; → TAKE.
  - TAKE: `flush`=1, `redirect`=1, `redirect_pc`=HANDLER_ADDR for exactly one cycle; → HANDLER unconditionally.
  - HANDLER: new exceptions ignored (EXL=1). `eret_D`=1 → RET.
  - RET: `flush`=1, `redirect`=1, `redirect_pc`=EPC for one cycle; EXL ← 0 at end of RET; → IDLE.
- `eret_D` outside HANDLER is ignored.
- `mtc0`:
  - Status writes bits[1:0] only.
  - EPC writes the full word.
  - Cause is read-only; writes are ignored, as are writes to other addresses.
- Write/accept collision: a same-cycle exception accept overrides `mtc0` to EPC and EXL; the IE bit from `mtc0` still takes effect.
- Write/eret collision: an `mtc0` to EPC in the same cycle as `eret_D` updates EPC before RET uses it.
- `cp0_rdata`: reg 12/13/14 content per `cp0_addr`, 0 for others. The read reflects register values before the current edge.

## Timing
- Reset values: Status=0, Cause=0, EPC=0, state IDLE; `flush`, `redirect`, `in_handler` = 0; `redirect_pc`=0.
- Accept latency: exception seen in cycle T → `flush`/`redirect` asserted in T+1.
- `flush` and `redirect` are registered outputs, are never asserted two cycles in a row, and are always asserted together.
- `eret_D` in cycle T (state HANDLER) → redirect to EPC in T+1, `in_handler`=0 from T+2.
- Exceptions arriving during TAKE or RET are ignored (EXL=1).
- The first accept is possible in the cycle after RET.
- Reset in any state, including mid-TAKE or mid-RET: next cycle is IDLE with all outputs at reset values and no redirect.

## Test plan
- Reset, then read regs 12/13/14 → all 0. Writes to Cause and to reg 5 leave `cp0_rdata` at 0.
- IE=0, `exc_req`=1, `int_cause`=0 → no flush, EPC unchanged. Then `mtc0` Status=1 and repeat with `pc_D`=0x0040_0010 → next cycle `redirect_pc`=0x8000_0180, EPC=0x0040_0010, ExcCode=0, `in_handler`=1.
- `int_cause`=4, `pc_E`=0x0040_0020, `pc_D`=0x0040_0024 → EPC=0x0040_0020, Cause=0x30 (ExcCode 12).
- In HANDLER, `int_cause`=1 pulse → ignored. Then `eret_D` → one-cycle redirect to EPC, EXL cleared next cycle, a subsequent syscall is accepted with ExcCode=8.
- `mtc0` EPC=0x0040_1000 plus `eret_D` in the same cycle → RET `redirect_pc`=0x0040_1000.
- Exception accept in cycle T, `rst` in T+1 → no redirect pulse after reset, Status/Cause/EPC=0.
